// File: rtl/wb_trace_capture.sv
// Writeback retirement trace capture: records go into a FIFO and drain as 3-word packets.
// Optional opcode filter enabled by defining TRACE_FILTER_EN (adds filt_en / filt_opcode).
module wb_trace_capture #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DROP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e_WB,
    input  logic [31:0]           aluout_WB,
    input  logic [31:0]           lmdout_WB,
    input  logic [4:0]            opcode_WB,
    input  logic [4:0]            pc_WB,
    input  logic [3:0]            destaddr_WB,
`ifdef TRACE_FILTER_EN
    input  logic                  filt_en,
    input  logic [4:0]            filt_opcode,
`endif
    output logic [31:0]           tr_data,
    output logic                  tr_valid,
    input  logic                  tr_ready,
    output logic                  tr_first,
    output logic                  tr_last,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int REC_W = 95;

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    state_t                 state_q;
    logic [REC_W-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2:0]    wr_ptr_q, rd_ptr_q;
    logic [15:0]            seq_q;
    logic                   lost_q;
    logic [DROP_W-1:0]      drop_q;
    logic [63:0]            hold_q;
    logic [31:0]            tr_data_q;
    logic                   tr_valid_q, tr_first_q, tr_last_q;

    logic [DEPTH_LOG2:0]    count_d;
    logic [REC_W-1:0]       rec_d, head_d;
    logic                   full_d, pop_d, cand_d, push_d, drop_d;

    assign count_d = wr_ptr_q - rd_ptr_q;
    assign full_d  = count_d[DEPTH_LOG2];
    assign head_d  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign rec_d   = {seq_q, lost_q, destaddr_WB, opcode_WB, pc_WB, aluout_WB, lmdout_WB};

`ifdef TRACE_FILTER_EN
    assign cand_d = e_WB && (!filt_en || (opcode_WB == filt_opcode));
`else
    assign cand_d = e_WB;
`endif

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign pop_d  = (count_d != '0) && ((state_q == IDLE) || ((state_q == W2) && tr_ready));
    assign push_d = cand_d && !(full_d && !pop_d);
    assign drop_d = cand_d && full_d && !pop_d;

    always_ff @(posedge clk) begin
        if (push_d) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rec_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            lost_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (push_d) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_d)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (e_WB)   seq_q    <= seq_q + 16'd1;
            if (push_d) begin
                lost_q <= 1'b0;
            end else if (drop_d) begin
                lost_q <= 1'b1;
            end
            if (drop_d && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            tr_data_q  <= '0;
            tr_valid_q <= 1'b0;
            tr_first_q <= 1'b0;
            tr_last_q  <= 1'b0;
        end else if (pop_d) begin
            state_q    <= W0;
            hold_q     <= head_d[63:0];
            tr_data_q  <= {head_d[94:79], 1'b0, head_d[78:64]};
            tr_valid_q <= 1'b1;
            tr_first_q <= 1'b1;
            tr_last_q  <= 1'b0;
        end else if (tr_ready) begin
            case (state_q)
                W0: begin
                    state_q    <= W1;
                    tr_first_q <= 1'b0;
                    tr_data_q  <= hold_q[63:32];
                end
                W1: begin
                    state_q    <= W2;
                    tr_last_q  <= 1'b1;
                    tr_data_q  <= hold_q[31:0];
                end
                W2: begin
                    state_q    <= IDLE;
                    tr_valid_q <= 1'b0;
                    tr_last_q  <= 1'b0;
                    tr_data_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign tr_data    = tr_data_q;
    assign tr_valid   = tr_valid_q;
    assign tr_first   = tr_first_q;
    assign tr_last    = tr_last_q;
    assign fifo_count = count_d;
    assign drop_cnt   = drop_q;

endmodule
